iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Multi-cycle ALU. It is the consumer of the 5-bit alu_op code that the ALU control unit produces.
- Computes add/logic/compare operations in one cycle. Computes shifts serially, one bit per cycle, to save area in the multi-cycle datapath.
- Accepts work with a start/busy/done handshake and holds the result and bcond until the next accepted operation.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OP_WIDTH, 5, width of the alu_op code.
- SHAMT_WIDTH, 5, shift-amount bits taken from in_b; equals clog2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only while idle (busy=0).
- alu_op  input  OP_WIDTH  operation code, sampled on the accept edge.
- in_a  input  DATA_WIDTH  operand A, sampled on the accept edge.
- in_b  input  DATA_WIDTH  operand B or shift amount, sampled on the accept edge.
- busy  output  1  high while a serial shift is in progress.
- done  output  1  one-cycle pulse when result/bcond are updated.
- result  output  DATA_WIDTH  registered result.
- bcond  output  1  registered branch condition.

Behaviour:
- Opcodes:
  - 00000 ADD; 00001 AND; 00010 OR; 00011 XOR.
  - 00100 SLL; 00101 SRL (logical); 00110 SUB.
  - 00111 BEQ; 01000 BNE; 01001 BLT (signed); 01010 BGE (signed).
  - Any other code, including 10011, is INVALID.
- Arithmetic is modulo 2^DATA_WIDTH; no overflow or carry flags.
- Branch ops: result = in_a - in_b; bcond per the compare.
- Non-branch ops: bcond = 0.
- INVALID: result = 0, bcond = 0, done still pulses.
- Shift amount = in_b[SHAMT_WIDTH-1:0]; upper bits of in_b are ignored.
- Reset (reset_n=0, asynchronous): state=IDLE; busy, done, bcond = 0; result = 0; internal counter and accumulator cleared.
- Reset mid-shift aborts the operation with no done pulse.
- State machine, IDLE and SHIFT:
  - busy = (state == SHIFT).
  - done is registered and defaults to 0 every cycle.
- IDLE with start=1 on a clock edge:
  - Non-shift op, or shift with shamt=0: result/bcond written on that edge, done=1 for the following cycle, stay IDLE. Latency 1; a shamt=0 shift returns in_a.
  - Shift with shamt>0: acc<=in_a, cnt<=shamt, direction latched, go to SHIFT; result/bcond hold their previous values.
- SHIFT, each edge:
  - acc shifts by 1 (left, or logical right) and cnt decrements.
  - On the edge where cnt==1: result<=shifted acc, bcond<=0, done<=1, go to IDLE.
  - Total latency = shamt cycles from the accept edge; busy is high for shamt cycles.
- start while busy=1 is ignored and dropped, with no side effects. alu_op/in_a/in_b may change freely during SHIFT.
- start on the cycle done=1 is accepted, since state is already IDLE. Back-to-back single-cycle ops give done every cycle.
- result and bcond are stable between done pulses.

Decomposition:
- Shared package/include: alu_op code constants (shared with the ALU control unit and ALU), the state encoding, and the DATA_WIDTH default.
- One natural sub-module: serial_shifter. It holds acc, cnt, direction, load/step and last-step outputs. The parent owns the FSM and the single-cycle datapath.

Test Plan:
- Reset, then ADD with in_a=0xFFFFFFFF, in_b=0x00000001, start for 1 cycle -> next cycle done=1, result=0x00000000, bcond=0, busy never high.
- SLL with in_a=0x00000001, in_b=0xFFFFFFE5 (shamt=5) -> busy high 5 cycles, done 5 cycles after accept, result=0x00000020. Repeat with SRL, in_a=0x80000000, shamt=31 -> result=0x00000001 after 31 cycles.
- BLT with in_a=0xFFFFFFFF, in_b=0x00000001 -> bcond=1, result=0xFFFFFFFE. BGE 5,5 -> bcond=1. BNE 5,5 -> bcond=0. BEQ 5,5 -> bcond=1.
- During SLL with shamt=10, pulse start with ADD at cycle 3 -> ignored; single done at cycle 10 with the shift result. Then start issued in the done cycle -> accepted, and its done follows 1 cycle later.
- Assert reset_n=0 mid-way through an SRL with shamt=20 -> busy, done, result immediately 0. After release, an XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> 0x0F0FF0F0.
- alu_op=10011 with in_a=in_b=0x12345678 -> done=1, result=0, bcond=0. Shamt=0 SLL with in_a=0xDEADBEEF -> done after 1 cycle, result=0xDEADBEEF.

Source files
------------

// File: rtl/iterative_alu_pkg.sv
// Shared definitions for the iterative ALU and the ALU control unit that feeds it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the alu_op code points, the ALU state encoding and the default datapath width.
package iterative_alu_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int OP_WIDTH_DEF    = 5;
    localparam int SHAMT_WIDTH_DEF = 5;

    // alu_op code points; every other code is treated as INVALID.
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_AND = 5'b00001;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_XOR = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRL = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_BEQ = 5'b00111;
    localparam logic [4:0] OP_BNE = 5'b01000;
    localparam logic [4:0] OP_BLT = 5'b01001;
    localparam logic [4:0] OP_BGE = 5'b01010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/iterative_alu_serial_shifter.sv
// Serial shifter: moves an accumulator one bit per step, left or logical right.
// Latency: one step per cycle; last is high on the step that completes the shift.
// Backpressure: none; the parent only asserts step while its shift is in flight.
//
// Ports: load/load_right/load_data/load_cnt seed a new shift; step advances it;
// shifted is the accumulator after one more step; last flags the final step.
module iterative_alu_serial_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic                   load_right,
    input  logic [DATA_WIDTH-1:0]  load_data,
    input  logic [SHAMT_WIDTH-1:0] load_cnt,
    input  logic                   step,
    output logic [DATA_WIDTH-1:0]  shifted,
    output logic                   last
);

    logic [DATA_WIDTH-1:0]  acc;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   right;

    assign shifted = right ? (acc >> 1) : (acc << 1);
    // cnt holds the steps still to do, so the final step is the one seeing 1.
    assign last    = step && (cnt == SHAMT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            right <= 1'b0;
        end else if (load) begin
            acc   <= load_data;
            cnt   <= load_cnt;
            right <= load_right;
        end else if (step) begin
            acc   <= shifted;
            cnt   <= cnt - SHAMT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: single-cycle add/logic/compare, bit-serial SLL/SRL.
// Latency: 1 cycle for non-shift ops and zero-amount shifts; shamt cycles for shifts.
// Backpressure: start is accepted only while busy=0; start during a shift is dropped.
//
// Ports: start/alu_op/in_a/in_b request an operation; busy marks a shift in progress;
// done pulses for one cycle when result/bcond are updated; both hold until the next done.
module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int OP_WIDTH    = OP_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  bcond
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    is_shift;
    logic                    shift_right;
    logic                    serial_go;
    logic                    last_step;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [DATA_WIDTH-1:0]   diff;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   comb_result;
    logic                    comb_bcond;

    assign shamt       = in_b[SHAMT_WIDTH-1:0];
    assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRL);
    assign shift_right = (alu_op == OP_SRL);
    assign accept      = start && (state == ST_IDLE);
    // A zero-amount shift completes on the single-cycle path and never enters SHIFT.
    assign serial_go   = accept && is_shift && (shamt != '0);
    assign diff        = in_a - in_b;
    assign busy        = (state == ST_SHIFT);

    // Single-cycle datapath; INVALID codes fall through to zero.
    always_comb begin
        comb_result = '0;
        comb_bcond  = 1'b0;
        case (alu_op)
            OP_ADD: comb_result = in_a + in_b;
            OP_AND: comb_result = in_a & in_b;
            OP_OR:  comb_result = in_a | in_b;
            OP_XOR: comb_result = in_a ^ in_b;
            OP_SLL: comb_result = in_a;
            OP_SRL: comb_result = in_a;
            OP_SUB: comb_result = diff;
            OP_BEQ: begin
                comb_result = diff;
                comb_bcond  = (in_a == in_b);
            end
            OP_BNE: begin
                comb_result = diff;
                comb_bcond  = (in_a != in_b);
            end
            OP_BLT: begin
                comb_result = diff;
                comb_bcond  = ($signed(in_a) < $signed(in_b));
            end
            OP_BGE: begin
                comb_result = diff;
                comb_bcond  = ($signed(in_a) >= $signed(in_b));
            end
            default: begin
                comb_result = '0;
                comb_bcond  = 1'b0;
            end
        endcase
    end

    iterative_alu_serial_shifter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (serial_go),
        .load_right (shift_right),
        .load_data  (in_a),
        .load_cnt   (shamt),
        .step       (busy),
        .shifted    (shifted),
        .last       (last_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (serial_go) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_step) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // result/bcond only move on a done edge, so they are stable between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            bcond  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !serial_go) begin
                result <= comb_result;
                bcond  <= comb_bcond;
                done   <= 1'b1;
            end else if (last_step) begin
                result <= shifted;
                bcond  <= 1'b0;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: scoreboard of expected results per accepted op.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario task does its own comparisons; a summary line closes the run.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        bcond;

    typedef struct packed {
        logic [31:0] res;
        logic        bc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    iterative_alu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .alu_op  (alu_op),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .bcond   (bcond)
    );

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = 32'h0;
        e.bc  = 1'b0;
        case (op)
            5'd0:  e.res = a + b;
            5'd1:  e.res = a & b;
            5'd2:  e.res = a | b;
            5'd3:  e.res = a ^ b;
            5'd4:  e.res = a << b[4:0];
            5'd5:  e.res = a >> b[4:0];
            5'd6:  e.res = a - b;
            5'd7:  begin e.res = a - b; e.bc = (a == b); end
            5'd8:  begin e.res = a - b; e.bc = (a != b); end
            5'd9:  begin e.res = a - b; e.bc = ($signed(a) < $signed(b)); end
            5'd10: begin e.res = a - b; e.bc = ($signed(a) >= $signed(b)); end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one start cycle from a falling edge; returns on the next falling edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_accept);
        start  = 1'b1;
        alu_op = op;
        in_a   = a;
        in_b   = b;
        if (expect_accept) sb.push_back(model(op, a, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // edges = clock edges after the accept edge until done is seen; bounded.
    task automatic wait_done(output int edges, output int busy_cnt, output bit timeout);
        edges    = 0;
        busy_cnt = 0;
        timeout  = 1'b0;
        while (!done) begin
            if (busy) busy_cnt++;
            if (edges >= 200) begin
                timeout = 1'b1;
                checks++;
                $display("FAIL wait_done: no done within %0d cycles", edges);
                return;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        alu_op  = 5'd0;
        in_a    = 32'h0;
        in_b    = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
        checks++; if (bcond !== 1'b0) $display("FAIL reset_bcond got %b want 0", bcond); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int e, b; bit to; exp_t x;
        issue(5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done(e, b, to);
        x = sb.pop_front();
        if (!to) begin
            checks++; if (result !== x.res) $display("FAIL add_result got %h want %h", result, x.res); else passed++;
            checks++; if (bcond !== x.bc) $display("FAIL add_bcond got %b want %b", bcond, x.bc); else passed++;
            checks++; if (e !== 0) $display("FAIL add_latency got %0d want 0 extra edges", e); else passed++;
            checks++; if (b !== 0) $display("FAIL add_busy got %0d busy cycles want 0", b); else passed++;
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL add_done_pulse got %b want 0", done); else passed++;
    endtask

    task automatic test_shift();
        int e, b; bit to; exp_t x; logic [31:0] prev;
        logic [31:0] a_tab [2];
        logic [31:0] b_tab [2];
        logic [4:0]  o_tab [2];
        int          s_tab [2];
        a_tab = '{32'h0000_0001, 32'h8000_0000};
        b_tab = '{32'hFFFF_FFE5, 32'h0000_001F};
        o_tab = '{5'd4, 5'd5};
        s_tab = '{5, 31};
        for (int i = 0; i < 2; i++) begin
            prev = result;
            issue(o_tab[i], a_tab[i], b_tab[i], 1'b1);
            checks++; if (result !== prev) $display("FAIL shift%0d_hold got %h want %h", i, result, prev); else passed++;
            wait_done(e, b, to);
            x = sb.pop_front();
            if (!to) begin
                checks++; if (result !== x.res) $display("FAIL shift%0d_result got %h want %h", i, result, x.res); else passed++;
                checks++; if (bcond !== 1'b0) $display("FAIL shift%0d_bcond got %b want 0", i, bcond); else passed++;
                checks++; if (e !== s_tab[i]) $display("FAIL shift%0d_latency got %0d want %0d", i, e, s_tab[i]); else passed++;
                checks++; if (b !== s_tab[i]) $display("FAIL shift%0d_busy got %0d want %0d", i, b, s_tab[i]); else passed++;
            end
        end
    endtask

    task automatic test_branch();
        int e, b; bit to; exp_t x;
        logic [4:0]  o_tab [4];
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        o_tab = '{5'd9, 5'd10, 5'd8, 5'd7};
        a_tab = '{32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5};
        b_tab = '{32'h0000_0001, 32'd5, 32'd5, 32'd5};
        for (int i = 0; i < 4; i++) begin
            issue(o_tab[i], a_tab[i], b_tab[i], 1'b1);
            wait_done(e, b, to);
            x = sb.pop_front();
            if (!to) begin
                checks++; if (result !== x.res) $display("FAIL branch%0d_result got %h want %h", i, result, x.res); else passed++;
                checks++; if (bcond !== x.bc) $display("FAIL branch%0d_bcond got %b want %b", i, bcond, x.bc); else passed++;
            end
        end
    endtask

    task automatic test_busy_ignore();
        int e, b; bit to; exp_t x;
        issue(5'd4, 32'h0000_0003, 32'd10, 1'b1);
        @(negedge clk);
        issue(5'd0, 32'h1, 32'h1, 1'b0);
        wait_done(e, b, to);
        x = sb.pop_front();
        if (!to) begin
            checks++; if (result !== x.res) $display("FAIL ignore_result got %h want %h", result, x.res); else passed++;
            checks++; if (e + 2 !== 10) $display("FAIL ignore_latency got %0d want 10", e + 2); else passed++;
        end
        // New request in the done cycle must be taken immediately.
        issue(5'd3, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
        x = sb.pop_front();
        checks++; if (done !== 1'b1) $display("FAIL done_cycle_accept_done got %b want 1", done); else passed++;
        checks++; if (result !== x.res) $display("FAIL done_cycle_accept_result got %h want %h", result, x.res); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL ignore_extra_done got %b want 0", done); else passed++;
    endtask

    task automatic test_reset_mid_shift();
        int e, b, n; bit to; exp_t x;
        issue(5'd5, 32'hFFFF_FFFF, 32'd20, 1'b1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else passed++;
        checks++; if (result !== 32'h0) $display("FAIL midreset_result got %h want 0", result); else passed++;
        x = sb.pop_front();
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        checks++; if (n !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", n); else passed++;
        issue(5'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1);
        wait_done(e, b, to);
        x = sb.pop_front();
        if (!to) begin
            checks++; if (result !== 32'h0F0F_F0F0) $display("FAIL post_reset_xor got %h want 0f0ff0f0", result); else passed++;
            checks++; if (result !== x.res) $display("FAIL post_reset_xor_sb got %h want %h", result, x.res); else passed++;
        end
    endtask

    task automatic test_invalid_shamt0();
        int e, b; bit to; exp_t x;
        issue(5'b10011, 32'h1234_5678, 32'h1234_5678, 1'b1);
        wait_done(e, b, to);
        x = sb.pop_front();
        if (!to) begin
            checks++; if (result !== 32'h0) $display("FAIL invalid_result got %h want 0", result); else passed++;
            checks++; if (bcond !== 1'b0) $display("FAIL invalid_bcond got %b want 0", bcond); else passed++;
            checks++; if (e !== 0) $display("FAIL invalid_latency got %0d want 0", e); else passed++;
        end
        issue(5'd4, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 1'b1);
        wait_done(e, b, to);
        x = sb.pop_front();
        if (!to) begin
            checks++; if (result !== x.res) $display("FAIL shamt0_result got %h want %h", result, x.res); else passed++;
            checks++; if (e !== 0) $display("FAIL shamt0_latency got %0d want 0", e); else passed++;
            checks++; if (b !== 0) $display("FAIL shamt0_busy got %0d want 0", b); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        logic [4:0]  o_tab [4];
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        o_tab = '{5'd0, 5'd6, 5'd1, 5'd2};
        a_tab = '{32'd10, 32'd5, 32'hFF00_FF00, 32'h0000_00F0};
        b_tab = '{32'd20, 32'd7, 32'h0FF0_0FF0, 32'h0F00_0000};
        for (int i = 0; i < 4; i++) begin
            start  = 1'b1;
            alu_op = o_tab[i];
            in_a   = a_tab[i];
            in_b   = b_tab[i];
            sb.push_back(model(o_tab[i], a_tab[i], b_tab[i]));
            @(negedge clk);
            x = sb.pop_front();
            checks++; if (done !== 1'b1) $display("FAIL b2b%0d_done got %b want 1", i, done); else passed++;
            checks++; if (result !== x.res) $display("FAIL b2b%0d_result got %h want %h", i, result, x.res); else passed++;
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL b2b_idle_done got %b want 0", done); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_branch();
        test_busy_ignore();
        test_reset_mid_shift();
        test_invalid_shamt0();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
